// File: rtl/pll_clock_ctrl.sv
// pll_clock_ctrl: lock-qualified reset sequencer and divided clock-enable strobes behind a PLL.
// Counts lock losses seen while running; all outputs are registered.
module pll_clock_ctrl #(
  parameter int LOCK_STABLE = 1024,
  parameter int RESET_HOLD  = 16,
  parameter int NUM_CE      = 2,
  parameter int DIV_W       = 8,
  parameter int CNT_W       = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    pll_locked,
  input  logic [NUM_CE*DIV_W-1:0] div,
  output logic                    rst_out,
  output logic                    ready,
  output logic [NUM_CE-1:0]       ce,
  output logic [CNT_W-1:0]        lock_lost_count
);
  localparam int MX = (LOCK_STABLE > RESET_HOLD) ? LOCK_STABLE : RESET_HOLD;
  localparam int CW = $clog2(MX + 1);
  typedef enum logic [1:0] {WAIT_LOCK, STABLE, HOLD, RUN} state_t;
  state_t            state_q, state_d;
  logic [1:0]        sync_q, sync_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]  lost_q, lost_d;
  logic              rst_out_q, ready_q;
  logic [NUM_CE-1:0] ce_q, ce_d;
  logic [DIV_W-1:0]  c_q [NUM_CE];
  logic [DIV_W-1:0]  c_d [NUM_CE];
  logic [DIV_W-1:0]  d_q [NUM_CE];
  logic [DIV_W-1:0]  d_d [NUM_CE];
  logic              lock_s, run_d, enter;
  assign lock_s = sync_q[1];
  assign sync_d = {sync_q[0], pll_locked};
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lost_d  = lost_q;
    if (!lock_s) begin
      state_d = WAIT_LOCK;
      lost_d  = (state_q == RUN && lost_q != '1) ? lost_q + 1'b1 : lost_q;
    end else begin
      unique case (state_q)
        WAIT_LOCK: begin
          state_d = STABLE;
          cnt_d   = '0;
        end
        STABLE: begin
          state_d = (cnt_q == CW'(LOCK_STABLE - 1)) ? HOLD : STABLE;
          cnt_d   = (cnt_q == CW'(LOCK_STABLE - 1)) ? '0 : cnt_q + 1'b1;
        end
        HOLD: begin
          state_d = (cnt_q == CW'(RESET_HOLD - 1)) ? RUN : HOLD;
          cnt_d   = cnt_q + 1'b1;
        end
        default: state_d = RUN;
      endcase
    end
  end
  // Counters hold the value for the upcoming cycle so ce can be registered without lag.
  assign run_d = (state_d == RUN);
  assign enter = run_d && (state_q != RUN);
  always_comb begin
    ce_d = '0;
    for (int i = 0; i < NUM_CE; i++) begin
      c_d[i]  = (!run_d || enter || c_q[i] == d_q[i]) ? '0 : c_q[i] + 1'b1;
      d_d[i]  = (enter || (state_q == RUN && c_q[i] == d_q[i])) ? div[i*DIV_W +: DIV_W] : d_q[i];
      ce_d[i] = run_d && (c_d[i] == '0);
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= WAIT_LOCK;
      sync_q    <= '0;
      cnt_q     <= '0;
      lost_q    <= '0;
      rst_out_q <= 1'b1;
      ready_q   <= 1'b0;
      ce_q      <= '0;
      c_q       <= '{default: '0};
      d_q       <= '{default: '0};
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      lost_q    <= lost_d;
      rst_out_q <= !run_d;
      ready_q   <= run_d;
      ce_q      <= ce_d;
      c_q       <= c_d;
      d_q       <= d_d;
    end
  end
  assign rst_out         = rst_out_q;
  assign ready           = ready_q;
  assign ce              = ce_q;
  assign lock_lost_count = lost_q;
endmodule

// File: doc/pll_clock_ctrl.md
Name: pll_clock_ctrl

Overview:
Clock-domain controller that sits directly behind a board PLL primitive (e.g. the 26 MHz iCEBreaker PLL). It runs on the PLL output clock and watches the PLL lock flag. It produces a clean, lock-qualified system reset and a set of parametrised clock-enable strobes that slower logic uses instead of extra PLL outputs. It also detects loss of lock, re-sequences reset and counts lock-loss events for debug.

Parameters:
LOCK_STABLE, 1024, consecutive cycles the synchronised lock must stay high before reset sequencing continues (>=1)
RESET_HOLD, 16, cycles rst_out stays high after lock is deemed stable (>=1)
NUM_CE, 2, number of clock-enable channels (>=1)
DIV_W, 8, width of each channel divide value
CNT_W, 8, width of lock-loss counter

Ports:
clock  in  1  PLL output clock; single clock domain
reset  in  1  asynchronous, active-high reset
pll_locked  in  1  raw PLL lock flag; asynchronous to clock
div  in  NUM_CE*DIV_W  channel i divide value in bits [i*DIV_W +: DIV_W]
rst_out  out  1  system reset to downstream logic; active-high
ready  out  1  high only in RUN state
ce  out  NUM_CE  per-channel one-cycle clock-enable strobes
lock_lost_count  out  CNT_W  saturating count of lock losses while in RUN

Behaviour:
- Reset (async assert, release on clock edge):
  - state=WAIT_LOCK; rst_out=1; ready=0; ce=0; lock_lost_count=0.
  - Sync flops, stability counter and channel counters all clear to 0.
- Lock synchroniser:
  - Two-flop chain, pll_locked -> lock_s.
  - Edge 0 is the first edge sampling pll_locked=1; lock_s=1 after edge 1.
- FSM, all outputs registered:
  - WAIT_LOCK: rst_out=1. If lock_s=1 -> STABLE, cnt=0.
  - STABLE: rst_out=1. If lock_s=0 -> WAIT_LOCK. Otherwise cnt++; at cnt==LOCK_STABLE-1 -> HOLD, cnt=0.
  - HOLD: rst_out=1. If lock_s=0 -> WAIT_LOCK. Otherwise cnt++; at cnt==RESET_HOLD-1 -> RUN.
  - RUN: rst_out=0, ready=1. If lock_s=0 -> WAIT_LOCK, lock_lost_count++ (saturates at all-ones, no wrap).
- Deassert timing: with lock held steady, rst_out and ready change after edge 2+LOCK_STABLE+RESET_HOLD.
- Lock loss in RUN: rst_out=1 and ready=0 after the edge where the FSM sees lock_s=0, i.e. 2 edges after pll_locked falls. Full re-sequence from WAIT_LOCK follows.
- A glitch of lock_s=0 in STABLE or HOLD restarts from WAIT_LOCK and does not increment lock_lost_count.
- Clock enables (active only in RUN; ce=0 in all other states):
  - Each channel has a counter c_i and a latched divide d_i.
  - On entering RUN: c_i=0 and d_i=div_i.
  - ce[i]=1 in the cycle c_i==0. Counter counts 0..d_i then wraps to 0, giving period d_i+1 cycles.
  - d_i=0 gives ce[i] constantly high during RUN.
  - div_i is re-latched into d_i only at wrap. A mid-period change of div never truncates or extends the current period.
  - The first ce pulse of every channel occurs in the first RUN cycle, the same cycle ready first reads 1.
  - Leaving RUN clears c_i and forces ce low from the next cycle.
- Async reset mid-operation: immediate return to reset values from any state. lock_lost_count clears; only reset clears it.
- Simultaneous events: lock_s falling in the same cycle HOLD would finish -> WAIT_LOCK wins (lock check has priority).

Test Plan:
- LOCK_STABLE=16, RESET_HOLD=4, pll_locked rises and stays high -> rst_out falls and ready rises exactly after edge 22; ce all 0 before that.
- Same config, pll_locked drops for 1 cycle at STABLE count 10 -> FSM returns to WAIT_LOCK; deassert occurs 22 edges after lock returns; lock_lost_count stays 0.
- In RUN, div0=3, div1=0 -> ce[0] pulses every 4 cycles starting at the first RUN cycle; ce[1] high every RUN cycle.
- In RUN, div0 changed 3->1 one cycle after a ce[0] pulse -> next pulse still 4 cycles later, then every 2 cycles.
- In RUN, pll_locked low -> rst_out=1 and ready=0 two edges later, ce=0, lock_lost_count=1. Repeat 300 times with CNT_W=8 -> count saturates at 255.
- Async reset asserted mid-RUN between clock edges -> rst_out=1, ready=0, ce=0, count=0 immediately without waiting for a clock edge.
